// File: rtl/register_file.sv
// Single-port register file: synchronous write, registered read, one op per cycle.
// Define REGFILE_RD_VALID_EN to add the registered RdValid output.
module register_file #(
    parameter  int MEM_WIDTH  = 16,
    parameter  int MEM_DEPTH  = 8,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic [MEM_WIDTH-1:0]  WrData,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  WrEn,
    input  logic                  RdEn,
`ifdef REGFILE_RD_VALID_EN
    output logic                  RdValid,
`endif
    output logic [MEM_WIDTH-1:0]  RdData
);

    logic [MEM_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [MEM_WIDTH-1:0] mem_d [MEM_DEPTH];
    logic [MEM_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 wr_ok, rd_ok;

    // Both enables high is illegal and treated as a no-op.
    assign wr_ok = WrEn & ~RdEn;
    assign rd_ok = RdEn & ~WrEn;

    always_comb begin
        mem_d     = mem_q;
        rd_data_d = rd_data_q;
        if (wr_ok) mem_d[Address] = WrData;
        if (rd_ok) rd_data_d = mem_q[Address];
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign RdData = rd_data_q;

`ifdef REGFILE_RD_VALID_EN
    logic rd_valid_q, rd_valid_d;

    assign rd_valid_d = rd_ok;

    always_ff @(posedge CLK) begin
        if (!RST_n) rd_valid_q <= 1'b0;
        else        rd_valid_q <= rd_valid_d;
    end

    assign RdValid = rd_valid_q;
`endif

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against a behavioural array model.
module tb_register_file;

    localparam int W = 16;
    localparam int D = 8;
    localparam int A = $clog2(D);

    logic         CLK = 1'b0;
    logic         RST_n;
    logic [W-1:0] WrData;
    logic [A-1:0] Address;
    logic         WrEn, RdEn;
    logic [W-1:0] RdData;
`ifdef REGFILE_RD_VALID_EN
    logic         RdValid;
`endif

    register_file #(.MEM_WIDTH(W), .MEM_DEPTH(D)) dut (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .WrData  (WrData),
        .Address (Address),
        .WrEn    (WrEn),
        .RdEn    (RdEn),
`ifdef REGFILE_RD_VALID_EN
        .RdValid (RdValid),
`endif
        .RdData  (RdData)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [W-1:0] ref_mem [D];
    logic [W-1:0] ref_rd;
    logic         ref_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model by the spec rules, then check.
    task automatic step(input logic rst_n, input logic we, input logic re,
                        input logic [A-1:0] addr, input logic [W-1:0] data);
        RST_n = rst_n; WrEn = we; RdEn = re; Address = addr; WrData = data;
        @(posedge CLK);
        if (!rst_n) begin
            foreach (ref_mem[i]) ref_mem[i] = '0;
            ref_rd  = '0;
            ref_vld = 1'b0;
        end else if (we && !re) begin
            ref_mem[addr] = data;
            ref_vld = 1'b0;
        end else if (re && !we) begin
            ref_rd  = ref_mem[addr];
            ref_vld = 1'b1;
        end else begin
            ref_vld = 1'b0;
        end
        @(negedge CLK);
        chk("rddata", {16'h0, RdData}, {16'h0, ref_rd});
`ifdef REGFILE_RD_VALID_EN
        chk("rdvalid", {31'h0, RdValid}, {31'h0, ref_vld});
`endif
    endtask

    initial begin
        RST_n = 1'b0; WrEn = 1'b0; RdEn = 1'b0; Address = '0; WrData = '0;
        ref_rd = '0; ref_vld = 1'b0;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        @(negedge CLK);

        // Reset then read
        step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        chk("reset_rddata", {16'h0, RdData}, 32'h0);
        step(1'b1, 1'b0, 1'b1, 3'd0, 16'h0);
        chk("read_after_reset", {16'h0, RdData}, 32'h0);

        // Write then read
        step(1'b1, 1'b1, 1'b0, 3'd0, 16'hFF00);
        chk("write_holds_rd", {16'h0, RdData}, 32'h0);
        step(1'b1, 1'b0, 1'b1, 3'd0, 16'h0);
        chk("raw_addr0", {16'h0, RdData}, 32'hFF00);

        // Reset clears contents
        step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        chk("reset_clears_rd", {16'h0, RdData}, 32'h0);
        step(1'b1, 1'b0, 1'b1, 3'd0, 16'h0);
        chk("reset_clears_mem", {16'h0, RdData}, 32'h0);

        // Simultaneous enables are a no-op
        step(1'b1, 1'b1, 1'b0, 3'd3, 16'h1234);
        step(1'b1, 1'b0, 1'b1, 3'd3, 16'h0);
        step(1'b1, 1'b1, 1'b1, 3'd7, 16'hFF00);
        chk("both_en_hold", {16'h0, RdData}, 32'h1234);
        step(1'b1, 1'b0, 1'b1, 3'd7, 16'h0);
        chk("both_en_nowrite", {16'h0, RdData}, 32'h0);

        // Hold across idle cycles
        step(1'b1, 1'b1, 1'b0, 3'd4, 16'hFF0F);
        step(1'b1, 1'b0, 1'b1, 3'd4, 16'h0);
        chk("read_addr4", {16'h0, RdData}, 32'hFF0F);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, A'(i), 16'hDEAD);
            chk("idle_hold", {16'h0, RdData}, 32'hFF0F);
        end

        // Full sweep
        for (int k = 0; k < D; k++) step(1'b1, 1'b1, 1'b0, A'(k), W'(k * 16'h1111));
        for (int k = 0; k < D; k++) begin
            step(1'b1, 1'b0, 1'b1, A'(k), 16'h0);
            chk("sweep", {16'h0, RdData}, 32'(k * 16'h1111));
        end
        step(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);

        // Random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            logic [1:0] en;
            en = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 49) != 0), en[1], en[0],
                 A'($urandom), W'($urandom));
        end

        // Final readback of every word
        for (int k = 0; k < D; k++) begin
            step(1'b1, 1'b0, 1'b1, A'(k), 16'h0);
            chk("final_mem", {16'h0, RdData}, {16'h0, ref_mem[k]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Single-port, synchronous-write, registered-read register file of MEM_DEPTH words, each MEM_WIDTH bits wide.
- One shared address bus serves both read and write; at most one operation (read or write) occurs per clock.
- Used as a general-purpose configuration and data store beside a processor or controller datapath.

Parameters:
- MEM_WIDTH, 16, data word width in bits (≥1).
- MEM_DEPTH, 8, number of words; power of two, ≥2.
- ADDR_WIDTH (localparam), $clog2(MEM_DEPTH), address width in bits.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_n  input  1  reset, synchronous and active-low; sampled on the CLK rising edge.
- WrData  input  MEM_WIDTH  write data word.
- Address  input  ADDR_WIDTH  word address for read or write.
- WrEn  input  1  write enable, active-high.
- RdEn  input  1  read enable, active-high.
- RdData  output  MEM_WIDTH  registered read data.

Behaviour:
- Single clock domain. All storage and RdData are flops clocked on the CLK rising edge. No asynchronous paths.
- Reset: when RST_n=0 at a rising edge, all MEM_DEPTH words clear to 0 and RdData clears to 0. Reset has priority over WrEn and RdEn. Any operation requested in that cycle is discarded.
- Write (WrEn=1, RdEn=0): mem[Address] <= WrData at the edge. RdData holds its previous value. The new data is readable from the next cycle.
- Read (RdEn=1, WrEn=0): RdData <= mem[Address] at the edge, so latency is 1 cycle. Memory is unchanged.
- Both enables high (WrEn=1, RdEn=1): illegal combination, so no operation. Memory is unchanged and RdData holds.
- Both enables low: idle. Memory and RdData hold. RdData is never cleared except by reset.
- Read-after-write to the same address in consecutive cycles returns the newly written data. No bypass is needed because the operations are in different cycles.
- Address covers all MEM_DEPTH words exactly; no out-of-range handling is required.
- No X-propagation from uninitialised storage after the first reset. Before the first reset, the contents are undefined.

Optional Feature:
- Macro REGFILE_RD_VALID_EN.
- When defined: add output RdValid (1 bit, registered). It is 1 for exactly the cycle after a legal read (RdEn=1, WrEn=0) and 0 otherwise. It is cleared by reset and is 0 when both enables are high.
- When not defined: the RdValid port and its logic do not exist. All other behaviour is identical.

Test Plan:
- Reset then read: RST_n=0 for one edge, release, RdEn=1 with Address=0 -> RdData=0x0000 after 1 cycle.
- Write then read: WrEn=1, Address=0, WrData=0xFF00; next cycle RdEn=1, Address=0 -> RdData=0xFF00 one edge later.
- Reset clears contents: after writing 0xFF00 to addr 0, pulse RST_n=0 for one edge, then read addr 0 -> RdData=0x0000.
- Simultaneous enables: WrEn=1, RdEn=1, Address=7, WrData=0xFF00 -> RdData unchanged. A subsequent legal read of addr 7 returns 0x0000 (no write occurred).
- Hold: write 0xFF0F to addr 4, read it (RdData=0xFF0F), then drop both enables for several cycles -> RdData stays 0xFF0F.
- Full sweep: write k*0x1111 to each address k=0..7, then read back all 8 in order -> each value returns with 1-cycle latency. With REGFILE_RD_VALID_EN defined, RdValid is high exactly on those 8 result cycles.
